router_modport: RTL and testbench

- 1x3 packet router: accepts byte-serial packets on one source port and routes each to one of three destination FIFOs selected by the header address.
- Source side has busy back-pressure and a parity error flag. Each destination side has a valid/read handshake.
- Sits between the packet source agent and three destination reader agents.

---
 rtl/router_pkg.sv | 25 ++
 rtl/router_fifo.sv | 70 +++++++
 rtl/router_modport.sv | 180 ++++++++++++++++++
 tb/tb_router_modport.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// router_pkg: shared FSM state encoding and defaults for the 1x3 router.
// Rev 1.0
// ============================================================================
package router_pkg;

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    WAIT_TILL_EMPTY    = 4'd1,
    LOAD_FIRST_DATA    = 4'd2,
    LOAD_DATA          = 4'd3,
    FIFO_FULL_STATE    = 4'd4,
    LOAD_AFTER_FULL    = 4'd5,
    LOAD_PARITY        = 4'd6,
    CHECK_PARITY_ERROR = 4'd7,
    DROP               = 4'd8
  } state_t;

  localparam logic [1:0] ADDR_INVALID            = 2'd3;
  localparam int         DEFAULT_FIFO_DEPTH      = 16;
  localparam int         DEFAULT_SOFT_RST_CYCLES = 30;

endpackage
`default_nettype wire

// File: rtl/router_fifo.sv
`default_nettype none
// ============================================================================
// router_fifo: 9-bit synchronous FIFO with flush and a registered read byte.
// Rev 1.0
// ============================================================================
module router_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       flush_i,
  input  logic       we_i,
  input  logic [8:0] wdata_i,
  input  logic       re_i,
  output logic [7:0] dout_o,
  output logic       empty_o,
  output logic       full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic [7:0]    dout_q;
  logic [8:0]    head;
  logic          do_rd;
  logic          do_wr;
  logic          unused_tag;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CW'(DEPTH));
  assign do_rd      = re_i && !empty_o;
  // A read on the same edge frees the slot, so a write while full still lands.
  assign do_wr      = we_i && (!full_o || do_rd);
  assign head       = mem_q[rptr_q];
  assign unused_tag = head[8];
  assign dout_o     = dout_q;

  always_ff @(posedge clock) begin
    if (!resetn || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + 1'b1;
      if (do_rd) rptr_q <= rptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clock) begin
    if (!resetn)    dout_q <= '0;
    else if (do_rd) dout_q <= head[7:0];
  end

endmodule
`default_nettype wire

// File: rtl/router_modport.sv
`default_nettype none
// ============================================================================
// router_modport: 1x3 byte-serial packet router with parity check and
// per-destination idle-read flush. Rev 1.0
// ============================================================================
module router_modport
  import router_pkg::*;
#(
  parameter int FIFO_DEPTH      = DEFAULT_FIFO_DEPTH,
  parameter int SOFT_RST_CYCLES = DEFAULT_SOFT_RST_CYCLES
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] data_in,
  input  logic       pkt_valid,
  output logic       busy,
  output logic       error,
  input  logic [2:0] read_enb,
  output logic [2:0] valid_out,
  output logic [7:0] data_out_0,
  output logic [7:0] data_out_1,
  output logic [7:0] data_out_2
);

  localparam int TW = $clog2(SOFT_RST_CYCLES + 1);

  state_t     state_q, state_d;
  logic [7:0] hdr_q, hdr_d;
  logic [7:0] parity_q, parity_d;
  logic [7:0] pkt_par_q, pkt_par_d;
  logic [7:0] hold_q, hold_d;
  logic       error_q, error_d;

  logic       wr_en;
  logic [8:0] fifo_wdata;
  logic [2:0] fifo_we;
  logic [2:0] empty;
  logic [2:0] full;
  logic [2:0] flush;
  logic [7:0] dout [3];
  logic [1:0] cur_addr;
  logic       writing;

  assign cur_addr   = hdr_q[1:0];
  assign fifo_we    = wr_en ? (3'b001 << cur_addr) : 3'b000;
  assign valid_out  = ~empty;
  assign error      = error_q;
  assign data_out_0 = dout[0];
  assign data_out_1 = dout[1];
  assign data_out_2 = dout[2];
  assign writing    = state_q inside {LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE,
                                      LOAD_AFTER_FULL, LOAD_PARITY};

  for (genvar i = 0; i < 3; i++) begin : g_dest
    logic [TW-1:0] tmo_q;

    router_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock   (clock),
      .resetn  (resetn),
      .flush_i (flush[i]),
      .we_i    (fifo_we[i]),
      .wdata_i (fifo_wdata),
      .re_i    (read_enb[i]),
      .dout_o  (dout[i]),
      .empty_o (empty[i]),
      .full_o  (full[i])
    );

    assign flush[i] = (tmo_q == TW'(SOFT_RST_CYCLES));

    always_ff @(posedge clock) begin
      if (!resetn || empty[i] || read_enb[i] || flush[i]) tmo_q <= '0;
      else                                                tmo_q <= tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= DECODE_ADDRESS;
      hdr_q     <= '0;
      parity_q  <= '0;
      pkt_par_q <= '0;
      hold_q    <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_q     <= hdr_d;
      parity_q  <= parity_d;
      pkt_par_q <= pkt_par_d;
      hold_q    <= hold_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    parity_d   = parity_q;
    pkt_par_d  = pkt_par_q;
    hold_d     = hold_q;
    error_d    = error_q;
    wr_en      = 1'b0;
    fifo_wdata = '0;
    busy       = 1'b0;
    case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid) begin
          if (data_in[1:0] == ADDR_INVALID) begin
            state_d = DROP;
          end else begin
            hdr_d   = data_in;
            error_d = 1'b0;
            state_d = empty[data_in[1:0]] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
      end
      WAIT_TILL_EMPTY: begin
        busy = 1'b1;
        if (empty[cur_addr]) state_d = LOAD_FIRST_DATA;
      end
      LOAD_FIRST_DATA: begin
        busy       = 1'b1;
        wr_en      = 1'b1;
        fifo_wdata = {1'b1, hdr_q};
        parity_d   = hdr_q;
        state_d    = LOAD_DATA;
      end
      LOAD_DATA: begin
        if (!pkt_valid) begin
          pkt_par_d = data_in;
          state_d   = LOAD_PARITY;
        end else if (full[cur_addr]) begin
          hold_d  = data_in;
          state_d = FIFO_FULL_STATE;
        end else begin
          wr_en      = 1'b1;
          fifo_wdata = {1'b0, data_in};
          parity_d   = parity_q ^ data_in;
        end
      end
      FIFO_FULL_STATE: begin
        busy = 1'b1;
        if (!full[cur_addr]) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        busy       = 1'b1;
        wr_en      = 1'b1;
        fifo_wdata = {1'b0, hold_q};
        parity_d   = parity_q ^ hold_q;
        // Source is stalled here, so a low pkt_valid means data_in is the parity.
        if (pkt_valid) begin
          state_d = LOAD_DATA;
        end else begin
          pkt_par_d = data_in;
          state_d   = LOAD_PARITY;
        end
      end
      LOAD_PARITY: begin
        busy = 1'b1;
        if (!full[cur_addr]) begin
          wr_en      = 1'b1;
          fifo_wdata = {1'b0, pkt_par_q};
          state_d    = CHECK_PARITY_ERROR;
        end
      end
      CHECK_PARITY_ERROR: begin
        busy    = 1'b1;
        error_d = (parity_q != pkt_par_q);
        state_d = DECODE_ADDRESS;
      end
      DROP: begin
        if (!pkt_valid) state_d = DECODE_ADDRESS;
      end
      default: state_d = DECODE_ADDRESS;
    endcase
    if (writing && flush[cur_addr]) state_d = DECODE_ADDRESS;
  end

endmodule
`default_nettype wire

// File: tb/tb_router_modport.sv
`default_nettype none
// ============================================================================
// tb_router_modport: directed self-checking bench for the 1x3 packet router.
// Rev 1.0
// ============================================================================
module tb_router_modport;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] data_in;
  logic       pkt_valid;
  logic       busy;
  logic       error;
  logic [2:0] read_enb;
  logic [2:0] valid_out;
  logic [7:0] data_out_0, data_out_1, data_out_2;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  router_modport dut (
    .clock      (clk),
    .resetn     (resetn),
    .data_in    (data_in),
    .pkt_valid  (pkt_valid),
    .busy       (busy),
    .error      (error),
    .read_enb   (read_enb),
    .valid_out  (valid_out),
    .data_out_0 (data_out_0),
    .data_out_1 (data_out_1),
    .data_out_2 (data_out_2)
  );

  always #5 clk = ~clk;

  // Log every byte a destination read delivers.
  always @(posedge clk) begin
    logic [2:0] rd;
    rd = read_enb & valid_out;
    #1;
    if (rd[0]) q0.push_back(data_out_0);
    if (rd[1]) q1.push_back(data_out_1);
    if (rd[2]) q2.push_back(data_out_2);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte and return once an edge with busy=0 has consumed it.
  task automatic send(input logic [7:0] b, input logic pv);
    int guard;
    data_in   = b;
    pkt_valid = pv;
    guard     = 0;
    while (busy === 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("send_busy_timeout", 32'(guard), 32'd0);
    @(negedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] bytes[$]);
    for (int k = 0; k < bytes.size(); k++)
      send(bytes[k], (k != bytes.size() - 1));
    pkt_valid = 1'b0;
    data_in   = 8'h00;
  endtask

  task automatic check_queue(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
    logic [7:0] v;
    check({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
    for (int k = 0; k < exp.size(); k++) begin
      v = (k < got.size()) ? got[k] : 8'hxx;
      check($sformatf("%s_byte%0d", tag, k), {24'd0, v}, {24'd0, exp[k]});
    end
  endtask

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] par;

    resetn    = 1'b0;
    data_in   = 8'h00;
    pkt_valid = 1'b0;
    read_enb  = 3'b000;
    repeat (2) @(negedge clk);
    check("reset_busy",  {31'd0, busy},       32'd0);
    check("reset_error", {31'd0, error},      32'd0);
    check("reset_valid", {29'd0, valid_out},  32'd0);
    check("reset_dout0", {24'd0, data_out_0}, 32'd0);
    check("reset_dout1", {24'd0, data_out_1}, 32'd0);
    check("reset_dout2", {24'd0, data_out_2}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Good packet to destination 1, stored then read out.
    send_pkt('{8'h0D, 8'hAA, 8'hBB, 8'hCC, 8'hD0});
    repeat (3) @(negedge clk);
    check("p1_valid", {29'd0, valid_out}, 32'h2);
    check("p1_error", {31'd0, error},     32'd0);
    q1.delete();
    read_enb = 3'b010;
    repeat (8) @(negedge clk);
    check_queue("p1_data", q1, '{8'h0D, 8'hAA, 8'hBB, 8'hCC, 8'hD0});
    check("p1_drained", {29'd0, valid_out}, 32'd0);

    // Same packet with a corrupt parity byte.
    q1.delete();
    send_pkt('{8'h0D, 8'hAA, 8'hBB, 8'hCC, 8'h00});
    repeat (3) @(negedge clk);
    check("p2_error_set", {31'd0, error}, 32'd1);
    repeat (5) @(negedge clk);
    check("p2_count", 32'(q1.size()), 32'd5);
    check("p2_error_held", {31'd0, error}, 32'd1);
    read_enb = 3'b000;

    // 20-byte payload to destination 0 overflows the 16-entry FIFO.
    q0.delete();
    exp_q.delete();
    exp_q.push_back(8'h50);
    par = 8'h50;
    send(8'h50, 1'b1);
    check("p3_error_cleared", {31'd0, error}, 32'd0);
    for (int k = 0; k < 16; k++) begin
      send(8'h10 + 8'(k), 1'b1);
      exp_q.push_back(8'h10 + 8'(k));
      par ^= 8'h10 + 8'(k);
    end
    check("p3_full_busy",  {31'd0, busy},      32'd1);
    check("p3_full_valid", {29'd0, valid_out}, 32'h1);
    read_enb = 3'b001;
    for (int k = 16; k < 20; k++) begin
      send(8'h10 + 8'(k), 1'b1);
      exp_q.push_back(8'h10 + 8'(k));
      par ^= 8'h10 + 8'(k);
    end
    exp_q.push_back(par);
    send(par, 1'b0);
    pkt_valid = 1'b0;
    repeat (30) @(negedge clk);
    check_queue("p3_data", q0, exp_q);
    check("p3_error", {31'd0, error}, 32'd0);
    read_enb = 3'b000;

    // Unread destination 2 is flushed by the idle-read timeout.
    q2.delete();
    send_pkt('{8'h06, 8'h5A, 8'h5C});
    check("p4_valid", {29'd0, valid_out}, 32'h4);
    repeat (20) @(negedge clk);
    check("p4_valid_before_flush", {29'd0, valid_out}, 32'h4);
    repeat (10) @(negedge clk);
    check("p4_flushed", {29'd0, valid_out}, 32'd0);
    check("p4_no_reads", 32'(q2.size()), 32'd0);

    // Address 3 is dropped, and the next packet still routes correctly.
    send_pkt('{8'h07, 8'h11, 8'h16});
    repeat (3) @(negedge clk);
    check("drop_valid", {29'd0, valid_out}, 32'd0);
    check("drop_busy",  {31'd0, busy},      32'd0);
    check("drop_error", {31'd0, error},     32'd0);
    q0.delete();
    read_enb = 3'b001;
    send_pkt('{8'h04, 8'h77, 8'h73});
    repeat (8) @(negedge clk);
    check_queue("p5_data", q0, '{8'h04, 8'h77, 8'h73});
    read_enb = 3'b000;

    // Reset in the middle of a packet.
    send(8'h0D, 1'b1);
    send(8'hAA, 1'b1);
    check("mid_valid", {29'd0, valid_out}, 32'h2);
    resetn = 1'b0;
    @(negedge clk);
    check("mid_rst_busy",  {31'd0, busy},       32'd0);
    check("mid_rst_valid", {29'd0, valid_out},  32'd0);
    check("mid_rst_dout0", {24'd0, data_out_0}, 32'd0);
    check("mid_rst_error", {31'd0, error},      32'd0);
    resetn    = 1'b1;
    pkt_valid = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
